// File: rtl/cpu_types_pkg.sv
// Shared types for the unified-RAM arbiter: word type, RAM handshake state
// and the arbiter grant states.
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of data grants completed while a fetch waits.
// o_sat reflects the value the counter takes at the coming edge.
module arb_starve_ctr #(
    parameter int STARVE_MAX = 4
) (
    input  logic CLK,
    input  logic nRST,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_sat
);

    localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] C_MAX = CW'(STARVE_MAX);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (i_clr)
            w_cnt_nxt = '0;
        else if (i_inc && (r_cnt != C_MAX))
            w_cnt_nxt = r_cnt + 1'b1;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            r_cnt <= '0;
        else
            r_cnt <= w_cnt_nxt;
    end

    // Arbitration at a completing edge must see the post-update count.
    assign o_sat = (w_cnt_nxt == C_MAX);

endmodule

// File: rtl/mem_arbiter.sv
// Unified RAM port arbiter between instruction fetch and data access.
// Optional build macro MEM_ARB_STATS_EN adds grant/conflict statistics counters.
//
// state | meaning
// IDLE  | no grant, RAM strobes low, arbitrate every cycle
// IGNT  | fetch owns the RAM port until ACCESS or iREN drops
// DGNT  | data owns the RAM port until ACCESS or request drops
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic [DATA_W-1:0] iload,
    output logic              iwait,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic [DATA_W-1:0] dload,
    output logic              dwait,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic              arb_err,
    output logic [31:0]       stat_icyc,
    output logic [31:0]       stat_conf
);

    arb_state_t r_state;
    arb_state_t w_state_nxt;
    arb_state_t w_arb;
    ramstate_t  w_rs;
    logic       w_dreq;
    logic       w_access;
    logic       w_inc;
    logic       w_clr;
    logic       w_sat;
    logic       r_err;

    assign w_rs     = ramstate_t'(ramstate);
    assign w_dreq   = dREN | dWEN;
    assign w_access = (w_rs == ACCESS);

    assign iload = ramload;
    assign dload = ramload;

    assign w_inc = (r_state == DGNT) & w_dreq & w_access & iREN;
    assign w_clr = ~iREN | ((r_state == IGNT) & iREN & w_access);

    arb_starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve (
        .CLK   (CLK),
        .nRST  (nRST),
        .i_inc (w_inc),
        .i_clr (w_clr),
        .o_sat (w_sat)
    );

    always_comb begin
        w_arb = IDLE;
        if (w_dreq && iREN)
            w_arb = w_sat ? IGNT : DGNT;
        else if (w_dreq)
            w_arb = DGNT;
        else if (iREN)
            w_arb = IGNT;
    end

    always_comb begin
        w_state_nxt = r_state;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        iwait       = iREN;
        dwait       = w_dreq;
        case (r_state)
            IDLE: w_state_nxt = w_arb;
            DGNT: begin
                if (!w_dreq) begin
                    w_state_nxt = IDLE;
                end else begin
                    ramWEN   = dWEN;
                    ramREN   = dREN & ~dWEN;
                    ramaddr  = daddr;
                    ramstore = dstore;
                    dwait    = ~w_access;
                    if (w_access)
                        w_state_nxt = w_arb;
                end
            end
            IGNT: begin
                if (!iREN) begin
                    w_state_nxt = IDLE;
                end else begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr;
                    iwait   = ~w_access;
                    if (w_access)
                        w_state_nxt = w_arb;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    // ERROR is retried like BUSY but leaves a sticky flag for software.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            r_err <= 1'b0;
        else if ((r_state != IDLE) && (w_rs == ERROR))
            r_err <= 1'b1;
    end

    assign arb_err = r_err;

`ifdef MEM_ARB_STATS_EN
    word_t r_icyc;
    word_t r_conf;
    logic  w_arb_cyc;

    assign w_arb_cyc = (r_state == IDLE)
                     | ((r_state == DGNT) & w_dreq & w_access)
                     | ((r_state == IGNT) & iREN & w_access);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_icyc <= '0;
            r_conf <= '0;
        end else begin
            if (r_state == IGNT)
                r_icyc <= r_icyc + 1'b1;
            if (w_arb_cyc && iREN && w_dreq)
                r_conf <= r_conf + 1'b1;
        end
    end

    assign stat_icyc = r_icyc;
    assign stat_conf = r_conf;
`else
    assign stat_icyc = '0;
    assign stat_conf = '0;
`endif

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the single unified RAM port between the instruction-fetch requester and the data-memory requester of the pipelined core.
- Registered-grant FSM with data priority, bounded by a starvation counter so fetch always progresses.
- Drives the per-requester wait signals consumed by the pipeline stall logic.
- Sits between the core's memory-request interface and the RAM model/controller.

Parameters:
- STARVE_MAX, 4: consecutive data grants allowed while a fetch is pending before fetch is forced.
- ADDR_W, 32: address width.
- DATA_W, 32: data word width.

Ports:
- CLK  in  1  system clock, rising edge
- nRST  in  1  asynchronous active-low reset
- iREN  in  1  instruction read request
- iaddr  in  ADDR_W  instruction address
- iload  out  DATA_W  instruction data returned
- iwait  out  1  high while fetch not complete
- dREN  in  1  data read request
- dWEN  in  1  data write request
- daddr  in  ADDR_W  data address
- dstore  in  DATA_W  write data
- dload  out  DATA_W  read data returned
- dwait  out  1  high while data access not complete
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  ADDR_W  RAM address
- ramstore  out  DATA_W  RAM write data
- ramload  in  DATA_W  RAM read data
- ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3
- arb_err  out  1  sticky RAM error flag
- stat_icyc  out  32  fetch-granted cycle count (see Optional Feature)
- stat_conf  out  32  conflict cycle count (see Optional Feature)

Behaviour:
- Clock and reset: one clock, CLK. Reset nRST is asynchronous and active-low.
- Reset values:
  - State = IDLE; starvation counter = 0.
  - ramREN, ramWEN, arb_err and both stats = 0.
  - ramaddr, ramstore = 0.
  - iwait, dwait = 1 whenever the corresponding request is high. Otherwise 0.
  - iload, dload = ramload passthrough.
- States: IDLE, IGNT, DGNT.
- Transitions from IDLE, evaluated at the clock edge:
  - Data request only (dREN|dWEN): go to DGNT.
  - iREN only: go to IGNT.
  - Both pending: DGNT, unless the starvation counter equals STARVE_MAX, in which case IGNT.
  - Neither: stay in IDLE.
- Latency: a request seen at edge n is granted in cycle n+1. RAM strobes are a combinational decode of the registered state and the granted requester's inputs. Minimum completion is cycle n+1 if ramstate==ACCESS in that cycle.
- Outputs in DGNT:
  - ramWEN=dWEN. ramREN=dREN&~dWEN, so a write wins if both are asserted.
  - ramaddr=daddr, ramstore=dstore.
  - dwait=~(ramstate==ACCESS). iwait=iREN.
- Outputs in IGNT:
  - ramREN=1, ramaddr=iaddr.
  - iwait=~(ramstate==ACCESS). dwait=dREN|dWEN.
- Completion: in a cycle with ramstate==ACCESS, the grant ends and the next state is the same IDLE arbitration, applied directly. No bubble cycle is inserted, so back-to-back grants are legal.
- Starvation counter:
  - Increments on each DGNT completion while iREN is high. Saturates at STARVE_MAX.
  - Clears on IGNT completion, or when iREN is low.
- Requester drops its request mid-grant: return to IDLE next edge. No RAM strobe is driven in the cycle after the drop.
- ramstate FREE/BUSY during a grant: hold the grant and strobes.
- ramstate ERROR: treated as BUSY (retry). Sets arb_err, which is cleared only by reset.
- Reset mid-grant: strobes deassert immediately (asynchronously) and state goes to IDLE.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- Defined:
  - stat_icyc increments every cycle in IGNT.
  - stat_conf increments every IDLE arbitration cycle in which both requesters are pending.
  - Both are 32-bit counters that wrap modulo 2^32 and reset to 0.
- Undefined: both outputs are tied to 0 and no counter registers are built.

Decomposition:
- cpu_types_pkg holds: word_t (DATA_W), ramstate_t enum (FREE, BUSY, ACCESS, ERROR), and arb_state_t enum (IDLE, IGNT, DGNT).
- One sub-module, arb_starve_ctr: a saturating counter with inc/clr/sat ports, parameterised by STARVE_MAX.
- The arbiter FSM and output decode stay in mem_arbiter.

Test Plan:
- Fetch only: iREN=1, iaddr=0x100, ramstate=ACCESS on the 2nd granted cycle. Expect ramREN=1, ramaddr=0x100, iwait low only in the ACCESS cycle, iload=ramload (0xDEADBEEF).
- Conflict: iREN=1 and dWEN=1 (daddr=0x200, dstore=0x55) in the same cycle. Expect DGNT first with ramWEN=1 and ramaddr=0x200, iwait held high, then IGNT.
- Starvation: iREN=1 held with 5 consecutive data requests, STARVE_MAX=4. Expect 4 DGNT grants, then IGNT, then the counter returns to 0.
- dREN=dWEN=1: expect ramWEN=1, ramREN=0.
- ramstate=ERROR for 3 cycles then ACCESS during DGNT. Expect dwait high through the ERROR cycles, then completion, and arb_err=1 stays high until nRST.
- Async reset: nRST=0 mid-DGNT between clock edges. Expect ramREN=ramWEN=0 immediately and IDLE after release.
- With MEM_ARB_STATS_EN: 3 conflict cycles and 6 IGNT cycles give stat_conf=3, stat_icyc=6. Without the macro, both read 0.
